// File: rtl/mips_pkg.sv
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared types and widths for the MIPS pipeline stages.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

package mips_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int WORD_W     = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_RESP = 2'd2
    } mem_state_e;

endpackage

`default_nettype wire

// File: rtl/memunit_timer.sv
// ============================================================================
//  Module      : memunit_timer
//  Description : 8-bit wait counter for the data-memory request phase.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module memunit_timer #(
    parameter int MAX_WAIT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    // The count holds REQ cycles already completed, so the MAX_WAIT-th cycle
    // is the one where the count equals MAX_WAIT-1.
    localparam logic [7:0] c_LAST = 8'(MAX_WAIT - 1);

    logic [7:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable) begin
            r_count <= r_count + 8'd1;
        end
    end

    assign expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/memunit.sv
// ============================================================================
//  Module      : memunit
//  Description : MEM stage - word loads/stores over a req/ack port, one
//                write-back per accepted instruction. Optional alignment
//                check enabled by MEMUNIT_ALIGN_CHECK_EN.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none

module memunit
    import mips_pkg::*;
#(
    parameter int WIDTH    = WORD_W,
    parameter int MAX_WAIT = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    output logic                  ready_out,
    input  logic [WIDTH-1:0]      ALUout,
    input  logic [WIDTH-1:0]      busB,
    input  logic [REG_ADDR_W-1:0] Regout,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic                  RegWrite,
    output logic                  dmem_req,
    output logic                  dmem_we,
    output logic [WIDTH-1:0]      dmem_addr,
    output logic [WIDTH-1:0]      dmem_wdata,
    input  logic [WIDTH-1:0]      dmem_rdata,
    input  logic                  dmem_ack,
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_reg,
    output logic [WIDTH-1:0]      wb_data,
    output logic                  mem_err
);

    mem_state_e              r_state;
    mem_state_e              w_next;
    logic [WIDTH-1:0]        r_addr;
    logic [WIDTH-1:0]        r_wdata;
    logic [WIDTH-1:0]        r_data;
    logic [REG_ADDR_W-1:0]   r_reg;
    logic                    r_regwrite;
    logic                    r_load;
    logic                    r_store;
    logic                    r_err;
    logic                    w_expired;
    logic                    w_accept;
    logic                    w_is_mem;
    logic                    w_misaligned;
    logic                    w_reject;

    assign w_accept = (r_state == ST_IDLE) && valid_in;
    assign w_is_mem = MemRead || MemWrite;

`ifdef MEMUNIT_ALIGN_CHECK_EN
    assign w_misaligned = (ALUout[1:0] != 2'b00);
`else
    assign w_misaligned = 1'b0;
`endif

    // Rejected instructions skip the memory port and report the error directly.
    assign w_reject = (MemRead && MemWrite) || (w_is_mem && w_misaligned);

    memunit_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .clear   (w_accept),
        .enable  (r_state == ST_REQ),
        .expired (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (valid_in) w_next = (w_is_mem && !w_reject) ? ST_REQ : ST_RESP;
            ST_REQ:  if (dmem_ack || w_expired) w_next = ST_RESP;
            ST_RESP: w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_addr     <= '0;
            r_wdata    <= '0;
            r_data     <= '0;
            r_reg      <= '0;
            r_regwrite <= 1'b0;
            r_load     <= 1'b0;
            r_store    <= 1'b0;
            r_err      <= 1'b0;
        end else if (w_accept) begin
            r_addr     <= {ALUout[WIDTH-1:2], 2'b00};
            r_wdata    <= busB;
            r_data     <= ALUout;
            r_reg      <= Regout;
            r_regwrite <= RegWrite;
            r_load     <= MemRead && !MemWrite;
            r_store    <= MemWrite;
            r_err      <= w_reject;
        end else if (r_state == ST_REQ) begin
            // Ack takes priority over an expiry in the same cycle.
            if (dmem_ack) begin
                if (r_load) r_data <= dmem_rdata;
            end else if (w_expired) begin
                r_err <= 1'b1;
            end
        end
    end

    assign ready_out  = (r_state == ST_IDLE);
    assign dmem_req   = (r_state == ST_REQ);
    assign dmem_we    = (r_state == ST_REQ) && r_store;
    assign dmem_addr  = r_addr;
    assign dmem_wdata = r_wdata;
    assign wb_valid   = (r_state == ST_RESP);
    assign wb_we      = (r_state == ST_RESP) && r_regwrite && !r_store && !r_err;
    assign wb_reg     = r_reg;
    assign wb_data    = r_data;
    assign mem_err    = (r_state == ST_RESP) && r_err;

endmodule

`default_nettype wire

// File: tb/tb_memunit.sv
// ============================================================================
//  Module      : tb_memunit
//  Description : Scoreboard bench for memunit with a randomised memory model.
//  Revision    : 1.0  - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_memunit;

    localparam int W  = 32;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          valid_in = 1'b0;
    logic          ready_out;
    logic [W-1:0]  ALUout = '0;
    logic [W-1:0]  busB = '0;
    logic [4:0]    Regout = '0;
    logic          MemRead = 1'b0;
    logic          MemWrite = 1'b0;
    logic          RegWrite = 1'b0;
    logic          dmem_req;
    logic          dmem_we;
    logic [W-1:0]  dmem_addr;
    logic [W-1:0]  dmem_wdata;
    logic [W-1:0]  dmem_rdata;
    logic          dmem_ack;
    logic          wb_valid;
    logic          wb_we;
    logic [4:0]    wb_reg;
    logic [W-1:0]  wb_data;
    logic          mem_err;

    memunit #(.WIDTH(W), .MAX_WAIT(MW)) dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .ALUout(ALUout), .busB(busB), .Regout(Regout),
        .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_reg(wb_reg), .wb_data(wb_data),
        .mem_err(mem_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic        we;
        logic [4:0]  rg;
        logic [31:0] data;
        int          lat;
        int          acc;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
        int          cycles;
    } mreq_t;

    exp_t  exp_q[$];
    mreq_t mem_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    cyc      = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Issue one instruction; the expected outcome comes from the stage's rules.
    task automatic issue(input logic [31:0] alu, input logic [31:0] bb, input logic [4:0] rg,
                         input logic mr, input logic mw, input logic rw,
                         input int delay, input logic [31:0] rdata, input bit no_wb);
        exp_t  e;
        mreq_t m;
        int    waited;
        logic  is_mem;
        logic  reject;
        waited = 0;
        @(negedge clk);
        while (!ready_out && waited < 100) begin
            valid_in = 1'($urandom_range(0, 1));
            ALUout   = $urandom;
            busB     = $urandom;
            Regout   = 5'($urandom);
            MemRead  = 1'($urandom);
            MemWrite = 1'($urandom);
            RegWrite = 1'($urandom);
            @(negedge clk);
            waited++;
        end
        if (!ready_out) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: ready_out=%0b after %0d cycles, expected 1", ready_out, waited);
            valid_in = 1'b0;
            return;
        end
        ALUout = alu; busB = bb; Regout = rg;
        MemRead = mr; MemWrite = mw; RegWrite = rw;
        valid_in = 1'b1;

        is_mem = mr | mw;
        reject = mr & mw;
`ifdef MEMUNIT_ALIGN_CHECK_EN
        if (is_mem && alu[1:0] != 2'b00) reject = 1'b1;
`endif
        e.rg = rg; e.data = alu; e.err = 1'b0; e.we = 1'b0; e.lat = 1;
        m.addr = alu & 32'hFFFF_FFFC; m.we = mw; m.wdata = bb;
        m.delay = delay; m.rdata = rdata; m.cycles = MW;
        if (reject) begin
            e.err = 1'b1;
        end else if (!is_mem) begin
            e.we = rw;
        end else if (delay >= 1 && delay <= MW) begin
            m.cycles = delay;
            e.lat = delay + 1;
            e.we = rw & mr;
            if (mr) e.data = rdata;
        end else begin
            e.lat = MW + 1;
            e.err = 1'b1;
        end

        @(posedge clk);
        #1;
        valid_in = 1'b0;
        e.acc = cyc - 1;
        if (is_mem && !reject) mem_q.push_back(m);
        if (!no_wb) exp_q.push_back(e);
    endtask

    // Memory model: acks after the planned number of REQ cycles, stray acks elsewhere.
    initial begin
        mreq_t cur;
        int    rcount;
        rcount = 0;
        cur.addr = '0; cur.we = 1'b0; cur.wdata = '0; cur.delay = 0; cur.rdata = '0; cur.cycles = MW;
        dmem_ack = 1'b0;
        dmem_rdata = '0;
        forever begin
            @(negedge clk);
            if (reset) begin
                rcount = 0;
                dmem_ack = 1'b0;
            end else if (dmem_req) begin
                if (rcount == 0) begin
                    if (mem_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_dmem_req: addr=0x%08h, expected no request", dmem_addr);
                        cur.addr = dmem_addr; cur.we = dmem_we; cur.wdata = dmem_wdata;
                        cur.delay = 0; cur.cycles = MW;
                    end else begin
                        cur = mem_q.pop_front();
                    end
                end
                rcount++;
                chk("dmem_addr", dmem_addr, cur.addr);
                chk("dmem_we", 32'(dmem_we), 32'(cur.we));
                if (cur.we) chk("dmem_wdata", dmem_wdata, cur.wdata);
                chk("ready_out_in_req", 32'(ready_out), 32'd0);
                if (rcount == cur.delay) begin
                    dmem_ack = 1'b1;
                    dmem_rdata = cur.rdata;
                end else begin
                    dmem_ack = 1'b0;
                    dmem_rdata = $urandom;
                end
            end else begin
                if (rcount != 0) begin
                    chk("dmem_req_cycles", 32'(rcount), 32'(cur.cycles));
                    rcount = 0;
                end
                dmem_ack = ($urandom_range(0, 3) == 0);
                dmem_rdata = $urandom;
            end
        end
    end

    // Monitor: pops an expectation for every write-back the DUT presents.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (wb_valid) begin
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_wb_valid: wb_reg=%0d wb_data=0x%08h, expected none", wb_reg, wb_data);
                    end else begin
                        e = exp_q.pop_front();
                        chk("wb_latency", 32'(cyc - e.acc), 32'(e.lat));
                        chk("mem_err", 32'(mem_err), 32'(e.err));
                        chk("wb_we", 32'(wb_we), 32'(e.we));
                        chk("wb_reg", 32'(wb_reg), 32'(e.rg));
                        if (e.we) chk("wb_data", wb_data, e.data);
                        chk("ready_out_in_resp", 32'(ready_out), 32'd0);
                    end
                end else begin
                    chk("mem_err_quiet", 32'(mem_err), 32'd0);
                end
            end
        end
    end

    initial begin
        #400000;
        n_fail++;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int    waited;
        int    k;
        int    delay;
        logic  mr;
        logic  mw;
        logic [31:0] alu;

        #2;
        chk("rst_ready_out", 32'(ready_out), 32'd1);
        chk("rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("rst_dmem_we", 32'(dmem_we), 32'd0);
        chk("rst_dmem_addr", dmem_addr, 32'd0);
        chk("rst_dmem_wdata", dmem_wdata, 32'd0);
        chk("rst_wb_valid", 32'(wb_valid), 32'd0);
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_wb_reg", 32'(wb_reg), 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_mem_err", 32'(mem_err), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        issue(32'h0000_000A, 32'h0, 5'd4, 1'b0, 1'b0, 1'b1, 0, 32'h0, 1'b0);
        issue(32'h0000_0100, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 3, 32'hDEAD_BEEF, 1'b0);
        issue(32'h0000_0040, 32'h8, 5'd9, 1'b0, 1'b1, 1'b1, 1, 32'h0, 1'b0);
        issue(32'h0000_0080, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, 0, 32'h1234, 1'b0);
        issue(32'h0000_0084, 32'h0, 5'd3, 1'b1, 1'b0, 1'b1, MW, 32'hCAFE_0001, 1'b0);
        issue(32'h0000_0102, 32'h0, 5'd5, 1'b1, 1'b0, 1'b1, 2, 32'h55AA_55AA, 1'b0);
        issue(32'h0000_0010, 32'h77, 5'd6, 1'b1, 1'b1, 1'b1, 1, 32'h0, 1'b0);

        // Reset in the middle of a request: no write-back may appear.
        issue(32'h0000_0200, 32'h0, 5'd8, 1'b1, 1'b0, 1'b1, 0, 32'h0, 1'b1);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_rst_dmem_req", 32'(dmem_req), 32'd0);
        chk("async_rst_ready_out", 32'(ready_out), 32'd1);
        chk("async_rst_wb_valid", 32'(wb_valid), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        repeat (8) @(negedge clk);
        chk("post_rst_ready_out", 32'(ready_out), 32'd1);
        issue(32'h0000_1234, 32'h0, 5'd2, 1'b0, 1'b0, 1'b1, 0, 32'h0, 1'b0);

        for (int i = 0; i < 300; i++) begin
            k = $urandom_range(0, 9);
            mr = 1'b0;
            mw = 1'b0;
            if (k >= 3 && k < 6) mr = 1'b1;
            else if (k >= 6 && k < 9) mw = 1'b1;
            else if (k == 9) begin mr = 1'b1; mw = 1'b1; end
            alu = $urandom;
            if ($urandom_range(0, 1) == 1) alu[1:0] = 2'b00;
            delay = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MW + 1);
            issue(alu, $urandom, 5'($urandom), mr, mw, 1'($urandom), delay, $urandom, 1'b0);
            if ($urandom_range(0, 3) == 0) repeat (2) @(negedge clk);
        end

        waited = 0;
        while ((exp_q.size() != 0 || mem_q.size() != 0) && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        repeat (3) @(negedge clk);
        chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);
        chk("mem_queue_drained", 32'(mem_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
